// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial wide adder sequencer: drives an external 4-bit adder one nibble per cycle,
// LSB first, chaining carry, and returns the assembled sum on a valid/ready port.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    input  logic                   in_cin,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_cout,
    output logic                   out_ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          next_state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    result;
    logic [CW-1:0]   cnt;
    logic            cy;
    logic            cout_reg;
    logic            ovf_reg;
    logic            last_nibble;

    assign last_nibble = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid && in_ready) next_state = RUN;
            RUN:     if (last_nibble) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Adder operands come straight from the captured registers so the whole
    // adder path settles within the cycle that writes its result nibble.
    always_comb begin
        in_ready  = rst_n && (state == IDLE);
        out_valid = (state == DONE);
        add_a     = 4'h0;
        add_b     = 4'h0;
        add_cin   = 1'b0;
        if (state == RUN) begin
            add_a   = a_reg[{cnt, 2'b00} +: 4];
            add_b   = b_reg[{cnt, 2'b00} +: 4];
            add_cin = cy;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            result   <= '0;
            cnt      <= '0;
            cy       <= 1'b0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        cy    <= in_cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    result[{cnt, 2'b00} +: 4] <= add_sum;
                    cy <= add_cout;
                    if (last_nibble) begin
                        cnt      <= '0;
                        cout_reg <= add_cout;
                        ovf_reg  <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[3] != a_reg[W-1]);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_sum  = result;
    assign out_cout = cout_reg;
    assign out_ovf  = ovf_reg;

endmodule
